// File: rtl/pe_job_seq.sv
// Dot-product job sequencer for a single pe_core: clears the PE, feeds K operand pairs,
// waits out the PE latency and returns the result. Define PE_JOB_SEQ_PERF_EN for perf_bubbles.
module pe_job_seq #(
   parameter int W_IN   = 8,
   parameter int W_ACC  = 24,
   parameter int MAX_K  = 256,
   parameter int PE_LAT = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         job_valid,
   output logic                         job_ready,
   input  logic [$clog2(MAX_K+1)-1:0]   job_len,
   input  logic                         job_relu,
   input  logic                         abort,
   input  logic                         op_valid,
   output logic                         op_ready,
   input  logic [W_IN-1:0]              op_a,
   input  logic [W_IN-1:0]              op_b,
   output logic                         pe_en,
   output logic                         pe_reg_reset,
   output logic                         pe_mode_sel,
   output logic [W_IN-1:0]              pe_a,
   output logic [W_IN-1:0]              pe_b,
   input  logic [W_ACC-1:0]             pe_results,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [W_ACC-1:0]             res_data,
   output logic                         busy
`ifdef PE_JOB_SEQ_PERF_EN
   ,
   output logic [$clog2(MAX_K+1)+7:0]   perf_bubbles
`endif
);

   localparam int W_LEN = $clog2(MAX_K+1);
   localparam int W_DRN = (PE_LAT > 0) ? $clog2(PE_LAT+1) : 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } state_t;

   state_t             state;
   logic [W_LEN-1:0]   len_q;
   logic [W_LEN-1:0]   term_cnt;
   logic [W_LEN:0]     term_nxt;
   logic [W_DRN-1:0]   drain_cnt;

   // One extra bit so the compare against len_q cannot wrap when len_q == MAX_K.
   assign term_nxt = {1'b0, term_cnt} + (W_LEN+1)'(1);

   // NOTE: operands pass straight through so the PE sees them in the same cycle they are accepted;
   // pe_en is only ever high while op_ready is high, which is only in FEED.
   assign pe_en = op_ready & op_valid;
   assign pe_a  = op_a;
   assign pe_b  = op_b;

   // NOTE: all state and registered outputs use non-blocking assignments under an async reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         job_ready    <= 1'b1;
         op_ready     <= 1'b0;
         pe_reg_reset <= 1'b0;
         pe_mode_sel  <= 1'b0;
         res_valid    <= 1'b0;
         res_data     <= '0;
         busy         <= 1'b0;
         len_q        <= '0;
         term_cnt     <= '0;
         drain_cnt    <= '0;
`ifdef PE_JOB_SEQ_PERF_EN
         perf_bubbles <= '0;
`endif
      end else if (abort) begin
         // Abort wins over every transition; res_data keeps the last delivered result.
         state        <= IDLE;
         job_ready    <= 1'b1;
         op_ready     <= 1'b0;
         pe_reg_reset <= 1'b0;
         pe_mode_sel  <= 1'b0;
         res_valid    <= 1'b0;
         busy         <= 1'b0;
         term_cnt     <= '0;
         drain_cnt    <= '0;
`ifdef PE_JOB_SEQ_PERF_EN
         perf_bubbles <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (job_valid) begin
                  state        <= CLEAR;
                  len_q        <= job_len;
                  job_ready    <= 1'b0;
                  pe_reg_reset <= 1'b1;
                  pe_mode_sel  <= job_relu;
                  busy         <= 1'b1;
                  term_cnt     <= '0;
                  drain_cnt    <= '0;
               end
            end

            CLEAR: begin
               pe_reg_reset <= 1'b0;
`ifdef PE_JOB_SEQ_PERF_EN
               perf_bubbles <= '0;
`endif
               if (len_q != '0) begin
                  state    <= FEED;
                  op_ready <= 1'b1;
               end else begin
                  // Empty job: the PE accumulator is stale, so report zero without sampling it.
                  state     <= DONE;
                  res_data  <= '0;
                  res_valid <= 1'b1;
               end
            end

            FEED: begin
               if (op_valid) begin
                  term_cnt <= term_nxt[W_LEN-1:0];
                  if (term_nxt == {1'b0, len_q}) begin
                     state     <= DRAIN;
                     op_ready  <= 1'b0;
                     drain_cnt <= '0;
                  end
               end
`ifdef PE_JOB_SEQ_PERF_EN
               else if (perf_bubbles != '1) begin
                  perf_bubbles <= perf_bubbles + (W_LEN+8)'(1);
               end
`endif
            end

            DRAIN: begin
               // PE_LAT+1 cycles lets the last product land in pe_results before sampling.
               if (drain_cnt == W_DRN'(PE_LAT)) begin
                  state     <= DONE;
                  res_data  <= pe_results;
                  res_valid <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + W_DRN'(1);
               end
            end

            DONE: begin
               if (res_ready) begin
                  state       <= IDLE;
                  res_valid   <= 1'b0;
                  job_ready   <= 1'b1;
                  busy        <= 1'b0;
                  pe_mode_sel <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               job_ready <= 1'b1;
               op_ready  <= 1'b0;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
